// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl
//   Memory-mapped controller that configures and sequences one timer_wrapper.
//   Software programs START / PRESCALE shadow registers and CTRL; the FSM
//   copies the shadows into the active outputs on ARM and RELOAD, holds the
//   timer enabled while in RUN, and turns a rising edge on timer_done_i into a
//   sticky PEND flag plus an optional interrupt. Periodic mode re-arms the
//   timer by dropping enable for the single RELOAD cycle.
//
// Register map (addr_i):
//   0 CTRL      bit0 EN, bit1 PERIODIC, bit2 IE
//   1 START     start value shadow  [TIMER_BITS-1:0]
//   2 PRESCALE  prescaler shadow    [SCALER_BITS-1:0]
//   3 STATUS    bit0 PEND (write 1 clears), bit1 RUNNING (read-only),
//               bits[15:8] expiry count (only with TIMER_CTRL_EXPCNT_EN;
//               write bit8=1 clears it)
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   addr_i, wdata_i     bus word select and write data
//   we_i, re_i          single-cycle write / read strobes
//   rdata_o             registered read data, valid the cycle after re_i
//   timer_start_o       active start value      -> timer_wrapper start_i
//   timer_prescaler_o   active prescaler value  -> timer_wrapper prescaler_i
//   timer_enable_o      1 only while in RUN     -> timer_wrapper enable_i
//   timer_done_i        timer_wrapper done level
//   irq_o               registered PEND & IE
//
// Optional feature macro: TIMER_CTRL_EXPCNT_EN (8-bit saturating expiry count).
// -----------------------------------------------------------------------------
module timer_ctrl #(
  parameter int TIMER_BITS  = 30,
  parameter int SCALER_BITS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             addr_i,
  input  logic [31:0]            wdata_i,
  input  logic                   we_i,
  input  logic                   re_i,
  output logic [31:0]            rdata_o,
  output logic [TIMER_BITS-1:0]  timer_start_o,
  output logic [SCALER_BITS-1:0] timer_prescaler_o,
  output logic                   timer_enable_o,
  input  logic                   timer_done_i,
  output logic                   irq_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARM    = 2'd1,
    S_RUN    = 2'd2,
    S_RELOAD = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_START    = 2'd1;
  localparam logic [1:0] ADDR_PRESCALE = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;

  state_e                 state_q, state_d;
  logic                   en_q, en_d;
  logic                   periodic_q, periodic_d;
  logic                   ie_q, ie_d;
  logic [TIMER_BITS-1:0]  start_shadow_q, start_shadow_d;
  logic [SCALER_BITS-1:0] prescale_shadow_q, prescale_shadow_d;
  logic [TIMER_BITS-1:0]  start_active_q, start_active_d;
  logic [SCALER_BITS-1:0] prescale_active_q, prescale_active_d;
  logic                   pend_q, pend_d;
  logic                   irq_q, irq_d;
  logic                   done_q, done_d;
  logic                   enable_q, enable_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [7:0]             exp_cnt_rd;

  logic wr_ctrl, wr_start, wr_prescale, wr_status, expire;
  logic unused_wdata;

  assign wr_ctrl     = we_i && (addr_i == ADDR_CTRL);
  assign wr_start    = we_i && (addr_i == ADDR_START);
  assign wr_prescale = we_i && (addr_i == ADDR_PRESCALE);
  assign wr_status   = we_i && (addr_i == ADDR_STATUS);

  // Expiry is a rising edge of done seen while the timer is actually running.
  assign expire = (state_q == S_RUN) && timer_done_i && !done_q;

  // Bits above the register fields are deliberately ignored.
  assign unused_wdata = ^wdata_i;

  always_comb begin
    // NOTE: every _d defaults to its held value first, so no branch below can
    // leave a signal unassigned and infer a latch.
    state_d           = state_q;
    en_d              = en_q;
    periodic_d        = periodic_q;
    ie_d              = ie_q;
    start_shadow_d    = start_shadow_q;
    prescale_shadow_d = prescale_shadow_q;
    start_active_d    = start_active_q;
    prescale_active_d = prescale_active_q;
    pend_d            = pend_q;
    done_d            = timer_done_i;
    rdata_d           = rdata_q;

    if (wr_start)    start_shadow_d    = wdata_i[TIMER_BITS-1:0];
    if (wr_prescale) prescale_shadow_d = wdata_i[SCALER_BITS-1:0];

    // EN=1 while already armed/running leaves EN at 1, so only PERIODIC and
    // IE effectively change; the FSM below ignores it outside IDLE.
    if (wr_ctrl) begin
      en_d       = wdata_i[0];
      periodic_d = wdata_i[1];
      ie_d       = wdata_i[2];
    end

    // Shadows become active here; done history is wiped so the level left
    // over from the previous run is not mistaken for a fresh expiry.
    if (state_q == S_ARM || state_q == S_RELOAD) begin
      start_active_d    = start_shadow_q;
      prescale_active_d = prescale_shadow_q;
      done_d            = 1'b0;
    end

    case (state_q)
      S_IDLE:   if (wr_ctrl && wdata_i[0]) state_d = S_ARM;
      S_ARM:    state_d = S_RUN;
      S_RUN: begin
        if (expire) begin
          if (periodic_q) begin
            state_d = S_RELOAD;
          end else begin
            state_d = S_IDLE;
            en_d    = 1'b0;
          end
        end
      end
      S_RELOAD: state_d = S_RUN;
      default:  state_d = S_IDLE;
    endcase

    // Software abort overrides whatever the expiry would have chosen.
    if (wr_ctrl && !wdata_i[0]) state_d = S_IDLE;

    // Set wins over write-1-to-clear in the same cycle.
    if (wr_status && wdata_i[0]) pend_d = 1'b0;
    if (expire)                  pend_d = 1'b1;

    irq_d    = pend_q & ie_q;
    enable_d = (state_d == S_RUN);

    if (re_i) begin
      case (addr_i)
        ADDR_CTRL:     rdata_d = {29'd0, ie_q, periodic_q, en_q};
        ADDR_START:    rdata_d = 32'(start_shadow_q);
        ADDR_PRESCALE: rdata_d = 32'(prescale_shadow_q);
        default:       rdata_d = {16'd0, exp_cnt_rd, 6'd0, (state_q == S_RUN), pend_q};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order inside this block.
    if (reset) begin
      state_q           <= S_IDLE;
      en_q              <= 1'b0;
      periodic_q        <= 1'b0;
      ie_q              <= 1'b0;
      start_shadow_q    <= '0;
      prescale_shadow_q <= '0;
      start_active_q    <= '0;
      prescale_active_q <= '0;
      pend_q            <= 1'b0;
      irq_q             <= 1'b0;
      done_q            <= 1'b0;
      enable_q          <= 1'b0;
      rdata_q           <= '0;
    end else begin
      state_q           <= state_d;
      en_q              <= en_d;
      periodic_q        <= periodic_d;
      ie_q              <= ie_d;
      start_shadow_q    <= start_shadow_d;
      prescale_shadow_q <= prescale_shadow_d;
      start_active_q    <= start_active_d;
      prescale_active_q <= prescale_active_d;
      pend_q            <= pend_d;
      irq_q             <= irq_d;
      done_q            <= done_d;
      enable_q          <= enable_d;
      rdata_q           <= rdata_d;
    end
  end

`ifdef TIMER_CTRL_EXPCNT_EN
  logic [7:0] exp_cnt_q, exp_cnt_d;

  // A clear coinciding with an expiry leaves a count of 1, not 0.
  always_comb begin
    exp_cnt_d = exp_cnt_q;
    if (wr_status && wdata_i[8]) begin
      exp_cnt_d = expire ? 8'd1 : 8'd0;
    end else if (expire && exp_cnt_q != 8'hFF) begin
      exp_cnt_d = exp_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) exp_cnt_q <= '0;
    else       exp_cnt_q <= exp_cnt_d;
  end

  assign exp_cnt_rd = exp_cnt_q;
`else
  assign exp_cnt_rd = 8'd0;
`endif

  assign rdata_o           = rdata_q;
  assign timer_start_o     = start_active_q;
  assign timer_prescaler_o = prescale_active_q;
  assign timer_enable_o    = enable_q;
  assign irq_o             = irq_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_ctrl
//   Directed scenarios followed by randomized bus/done traffic. Every cycle the
//   DUT outputs are compared with a behavioural model of the controller that
//   tracks the software-visible registers and the timer's current phase.
// -----------------------------------------------------------------------------
module tb_timer_ctrl;

  localparam int TB = 30;
  localparam int SB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    addr_i;
  logic [31:0]   wdata_i;
  logic          we_i, re_i;
  logic [31:0]   rdata_o;
  logic [TB-1:0] timer_start_o;
  logic [SB-1:0] timer_prescaler_o;
  logic          timer_enable_o;
  logic          timer_done_i;
  logic          irq_o;

  int checks = 0;
  int errors = 0;

  timer_ctrl #(.TIMER_BITS(TB), .SCALER_BITS(SB)) dut (
    .clk               (clk),
    .reset             (reset),
    .addr_i            (addr_i),
    .wdata_i           (wdata_i),
    .we_i              (we_i),
    .re_i              (re_i),
    .rdata_o           (rdata_o),
    .timer_start_o     (timer_start_o),
    .timer_prescaler_o (timer_prescaler_o),
    .timer_enable_o    (timer_enable_o),
    .timer_done_i      (timer_done_i),
    .irq_o             (irq_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  localparam int P_IDLE = 0, P_ARM = 1, P_RUN = 2, P_RELOAD = 3;

  int          m_phase;
  bit          m_en, m_per, m_ie, m_pend, m_irq, m_done_prev;
  bit [TB-1:0] m_start_sh, m_start_act;
  bit [SB-1:0] m_pre_sh, m_pre_act;
  int          m_cnt;
  bit [31:0]   m_rdata;

  task automatic model_reset();
    m_phase = P_IDLE; m_en = 0; m_per = 0; m_ie = 0; m_pend = 0; m_irq = 0;
    m_done_prev = 0; m_start_sh = '0; m_start_act = '0; m_pre_sh = '0;
    m_pre_act = '0; m_cnt = 0; m_rdata = '0;
  endtask

  function automatic bit [31:0] m_read(input logic [1:0] a);
    bit [31:0] v;
    case (a)
      2'd0: v = 32'(m_en) | (32'(m_per) << 1) | (32'(m_ie) << 2);
      2'd1: v = 32'(m_start_sh);
      2'd2: v = 32'(m_pre_sh);
      default: begin
        v = 32'(m_pend) | (32'(m_phase == P_RUN) << 1);
`ifdef TIMER_CTRL_EXPCNT_EN
        v = v | (32'(m_cnt) << 8);
`endif
      end
    endcase
    return v;
  endfunction

  // Advances the model by one clock edge with the inputs sampled at that edge.
  task automatic model_edge(input logic we, input logic re, input logic [1:0] a,
                            input logic [31:0] wd, input logic done);
    bit fired, loading;
    int nxt;
    fired   = (m_phase == P_RUN) && done && !m_done_prev;
    loading = (m_phase == P_ARM) || (m_phase == P_RELOAD);
    if (re) m_rdata = m_read(a);
    m_irq = m_pend && m_ie;
    if (loading) begin
      m_start_act = m_start_sh;
      m_pre_act   = m_pre_sh;
    end
    m_done_prev = loading ? 1'b0 : done;

    if (m_phase == P_IDLE)      nxt = (we && a == 0 && wd[0]) ? P_ARM : P_IDLE;
    else if (m_phase == P_RUN)  nxt = fired ? (m_per ? P_RELOAD : P_IDLE) : P_RUN;
    else                        nxt = P_RUN;
    if (we && a == 0 && !wd[0]) nxt = P_IDLE;

    if (we && a == 0) begin
      m_en = wd[0]; m_per = wd[1]; m_ie = wd[2];
    end
    if (fired && m_phase == P_RUN && nxt == P_IDLE && !(we && a == 0 && !wd[0]) && m_en) m_en = 0;
    if (fired && nxt == P_IDLE) m_en = (we && a == 0 && wd[0] && m_phase != P_RUN) ? 1'b1 : 1'b0;
    if (we && a == 1) m_start_sh = wd[TB-1:0];
    if (we && a == 2) m_pre_sh   = wd[SB-1:0];
    if (we && a == 3 && wd[0]) m_pend = 0;
    if (fired) m_pend = 1;
    if (we && a == 3 && wd[8]) m_cnt = fired ? 1 : 0;
    else if (fired)            m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
    m_phase = nxt;
  endtask

  // ---------------- checking / stimulus helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic we, input logic re, input logic [1:0] a,
                       input logic [31:0] wd, input logic done);
    @(negedge clk);
    we_i = we; re_i = re; addr_i = a; wdata_i = wd; timer_done_i = done;
    @(posedge clk);
    model_edge(we, re, a, wd, done);
    #1;
    check("enable",    32'(timer_enable_o),    32'(m_phase == P_RUN));
    check("irq",       32'(irq_o),             32'(m_irq));
    check("start_act", 32'(timer_start_o),     32'(m_start_act));
    check("pre_act",   32'(timer_prescaler_o), 32'(m_pre_act));
    check("rdata",     rdata_o,                m_rdata);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d); cycle(1'b1, 1'b0, a, d, 1'b0); endtask
  task automatic rd(input logic [1:0] a);                      cycle(1'b0, 1'b1, a, '0, 1'b0); endtask
  task automatic idle(input logic done);                       cycle(1'b0, 1'b0, 2'd0, '0, done); endtask

`ifdef TIMER_CTRL_EXPCNT_EN
  localparam logic [31:0] CNT_ONE = 32'h100, CNT_THREE = 32'h300, CNT_SAT = 32'd255;
`else
  localparam logic [31:0] CNT_ONE = 32'h0,   CNT_THREE = 32'h0,   CNT_SAT = 32'd0;
`endif

  initial begin
    logic [31:0] stat;
    logic [31:0] wd;
    logic [1:0]  a;
    int          r;

    // Reset
    reset = 1'b1; we_i = 0; re_i = 0; addr_i = '0; wdata_i = '0; timer_done_i = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_enable", 32'(timer_enable_o), 32'd0);
    check("rst_irq",    32'(irq_o),          32'd0);
    check("rst_rdata",  rdata_o,             32'd0);
    check("rst_start",  32'(timer_start_o),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(2'(i));
      check("rst_read", rdata_o, 32'd0);
    end

    // One-shot with interrupt
    wr(2'd1, 32'd5);
    wr(2'd2, 32'd1);
    wr(2'd0, 32'h5);
    check("arm_enable", 32'(timer_enable_o), 32'd0);
    idle(1'b0);
    check("run_enable", 32'(timer_enable_o), 32'd1);
    check("run_start",  32'(timer_start_o), 32'd5);
    check("run_pre",    32'(timer_prescaler_o), 32'd1);
    idle(1'b1);
    check("os_enable",  32'(timer_enable_o), 32'd0);
    check("os_irq_lag", 32'(irq_o), 32'd0);
    idle(1'b0);
    check("os_irq",     32'(irq_o), 32'd1);
    rd(2'd0);
    check("os_ctrl",    rdata_o, 32'h4);
    rd(2'd3);
    check("os_status",  rdata_o, 32'h1 | CNT_ONE);
    wr(2'd3, 32'h1);
    idle(1'b0);
    check("clr_irq",    32'(irq_o), 32'd0);

    // Periodic: enable drops for exactly the reload cycle
    wr(2'd3, 32'h100);
    wr(2'd0, 32'h3);
    idle(1'b0);
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      check("per_reload_low", 32'(timer_enable_o), 32'd0);
      idle(1'b0);
      check("per_run_high",   32'(timer_enable_o), 32'd1);
    end
    rd(2'd3);
    check("per_status", rdata_o, 32'h3 | CNT_THREE);

    // Shadow START only reaches the timer at the next reload
    wr(2'd1, 32'd9);
    check("sh_hold0", 32'(timer_start_o), 32'd5);
    idle(1'b1);
    check("sh_hold1", 32'(timer_start_o), 32'd5);
    idle(1'b0);
    check("sh_new",   32'(timer_start_o), 32'd9);

    // Collision: done edge vs PEND clear, then done edge vs abort
    cycle(1'b1, 1'b0, 2'd3, 32'h1, 1'b1);
    idle(1'b0);
    rd(2'd3);
    check("col_pend_wins", 32'(rdata_o[0]), 32'd1);
    wr(2'd3, 32'h1);
    cycle(1'b1, 1'b0, 2'd0, 32'h0, 1'b1);
    check("col_abort_en", 32'(timer_enable_o), 32'd0);
    rd(2'd3);
    check("col_abort_st", 32'(rdata_o[1:0]), 32'd1);

    // Abort during RUN
    wr(2'd0, 32'h3);
    idle(1'b0);
    wr(2'd0, 32'h0);
    check("abort_enable", 32'(timer_enable_o), 32'd0);

    // Counter saturation over 300 periodic expiries
    wr(2'd3, 32'h101);
    wr(2'd0, 32'h3);
    idle(1'b0);
    for (int k = 0; k < 300; k++) begin
      idle(1'b1);
      idle(1'b0);
    end
    rd(2'd3);
    stat = rdata_o;
    check("sat_cnt", 32'(stat[15:8]), CNT_SAT);
    wr(2'd0, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 2500; n++) begin
      r  = $urandom_range(0, 99);
      wd = $urandom;
      a  = 2'($urandom_range(0, 3));
      if (r < 8) begin
        wd[0] = ($urandom_range(0, 3) != 0);
        cycle(1'b1, $urandom_range(0, 1) == 1, 2'd0, wd, $urandom_range(0, 9) == 0);
      end else if (r < 22) begin
        cycle(1'b1, $urandom_range(0, 1) == 1, a, wd, $urandom_range(0, 9) == 0);
      end else begin
        cycle(1'b0, $urandom_range(0, 1) == 1, a, wd, $urandom_range(0, 6) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
